// File: rtl/fifo_pkg.sv
`default_nettype none
// ============================================================================
// fifo_pkg : shared Gray/binary helpers and defaults for the async FIFO
//            read- and write-side pointer controllers.
// Revision  : 1.0
// ============================================================================
package fifo_pkg;

  localparam int DEFAULT_ADDR_W = 4;
  // Helpers work on a fixed wide vector; callers zero-extend and slice.
  localparam int PTR_MAX_W = 32;

  function automatic logic [PTR_MAX_W-1:0] bin2gray(input logic [PTR_MAX_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [PTR_MAX_W-1:0] gray2bin(input logic [PTR_MAX_W-1:0] g);
    logic [PTR_MAX_W-1:0] b;
    b[PTR_MAX_W-1] = g[PTR_MAX_W-1];
    for (int i = PTR_MAX_W-2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sync_nff.sv
`default_nettype none
// ============================================================================
// sync_nff : STAGES-deep flop chain bringing a Gray pointer into this domain.
// Revision : 1.0
// ============================================================================
module sync_nff #(
  parameter int WIDTH  = 1,
  parameter int STAGES = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] sync_q [STAGES];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int s = 0; s < STAGES; s++) begin
        sync_q[s] <= '0;
      end
    end else begin
      sync_q[0] <= d_i;
      for (int s = 1; s < STAGES; s++) begin
        sync_q[s] <= sync_q[s-1];
      end
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/rd_ptr_ctrl.sv
`default_nettype none
// ============================================================================
// rd_ptr_ctrl : async-FIFO read pointer, empty/almost-empty/fill flags.
//               RD_PTR_CTRL_UFLOW_CNT_EN adds a saturating underflow counter.
// Revision    : 1.0
// ============================================================================
module rd_ptr_ctrl
  import fifo_pkg::*;
#(
  parameter int ADDR_W      = DEFAULT_ADDR_W,
  parameter int SYNC_STAGES = 2,
  parameter int AE_THRESH   = 2
) (
  input  logic              rd_clk,
  input  logic              rst,
  input  logic              read_en,
  input  logic [ADDR_W:0]   wr_ptr_gray,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [ADDR_W:0]   rd_ptr_gray,
  output logic              empty,
  output logic              almost_empty,
  output logic [ADDR_W:0]   rd_fill,
  output logic              rd_valid,
  output logic              underflow
`ifdef RD_PTR_CTRL_UFLOW_CNT_EN
  ,
  output logic [7:0]        uflow_cnt
`endif
);

  localparam int PTR_W = ADDR_W + 1;

  logic [PTR_W-1:0]     bin_q, bin_d;
  logic [PTR_W-1:0]     gray_q, gray_d;
  logic [PTR_W-1:0]     fill_q, fill_d;
  logic                 empty_q, empty_d;
  logic                 ae_q, ae_d;
  logic                 valid_q, valid_d;
  logic                 uflow_q, uflow_d;
  logic [PTR_W-1:0]     wr_gray_sync;
  logic [PTR_W-1:0]     wr_bin_sync;
  logic [PTR_MAX_W-1:0] gray_next_full;
  logic [PTR_MAX_W-1:0] wr_bin_full;
  logic                 rd_accept;

  sync_nff #(
    .WIDTH  (PTR_W),
    .STAGES (SYNC_STAGES)
  ) u_wr_sync (
    .clk_i (rd_clk),
    .rst_i (rst),
    .d_i   (wr_ptr_gray),
    .q_o   (wr_gray_sync)
  );

  // Flags are computed from the post-read pointer so the last read sees empty at once.
  always_comb begin
    rd_accept      = read_en && !empty_q;
    bin_d          = bin_q + PTR_W'(rd_accept);
    gray_next_full = bin2gray(PTR_MAX_W'(bin_d));
    gray_d         = gray_next_full[PTR_W-1:0];
    wr_bin_full    = gray2bin(PTR_MAX_W'(wr_gray_sync));
    wr_bin_sync    = wr_bin_full[PTR_W-1:0];
    empty_d        = (gray_d == wr_gray_sync);
    fill_d         = wr_bin_sync - bin_d;
    ae_d           = (PTR_MAX_W'(fill_d) <= PTR_MAX_W'(AE_THRESH));
    valid_d        = rd_accept;
    uflow_d        = read_en && empty_q;
  end

  wire unused_hi = ^{gray_next_full[PTR_MAX_W-1:PTR_W], wr_bin_full[PTR_MAX_W-1:PTR_W]};

  always_ff @(posedge rd_clk or posedge rst) begin
    if (rst) begin
      bin_q   <= '0;
      gray_q  <= '0;
      fill_q  <= '0;
      empty_q <= 1'b1;
      ae_q    <= 1'b1;
      valid_q <= 1'b0;
      uflow_q <= 1'b0;
    end else begin
      bin_q   <= bin_d;
      gray_q  <= gray_d;
      fill_q  <= fill_d;
      empty_q <= empty_d;
      ae_q    <= ae_d;
      valid_q <= valid_d;
      uflow_q <= uflow_d;
    end
  end

`ifdef RD_PTR_CTRL_UFLOW_CNT_EN
  logic [7:0] ucnt_q, ucnt_d;

  always_comb begin
    ucnt_d = ucnt_q;
    if (uflow_q && (ucnt_q != 8'hFF)) begin
      ucnt_d = ucnt_q + 8'd1;
    end
  end

  always_ff @(posedge rd_clk or posedge rst) begin
    if (rst) begin
      ucnt_q <= '0;
    end else begin
      ucnt_q <= ucnt_d;
    end
  end

  assign uflow_cnt = ucnt_q;
`endif

  assign rd_addr      = bin_q[ADDR_W-1:0];
  assign rd_ptr_gray  = gray_q;
  assign empty        = empty_q;
  assign almost_empty = ae_q;
  assign rd_fill      = fill_q;
  assign rd_valid     = valid_q;
  assign underflow    = uflow_q;

endmodule
`default_nettype wire

// File: tb/tb_rd_ptr_ctrl.sv
`default_nettype none
// ============================================================================
// tb_rd_ptr_ctrl : vector table, corner sequences and a random run against
//                  a pointer-arithmetic reference model.
// Revision       : 1.0
// ============================================================================
module tb_rd_ptr_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       read_en;
  logic [4:0] wr_ptr_gray;
  logic [3:0] rd_addr;
  logic [4:0] rd_ptr_gray;
  logic       empty;
  logic       almost_empty;
  logic [4:0] rd_fill;
  logic       rd_valid;
  logic       underflow;
`ifdef RD_PTR_CTRL_UFLOW_CNT_EN
  logic [7:0] uflow_cnt;
`endif

  always #5 clk = ~clk;

  rd_ptr_ctrl #(
    .ADDR_W      (4),
    .SYNC_STAGES (2),
    .AE_THRESH   (2)
  ) dut (
    .rd_clk       (clk),
    .rst          (rst),
    .read_en      (read_en),
    .wr_ptr_gray  (wr_ptr_gray),
    .rd_addr      (rd_addr),
    .rd_ptr_gray  (rd_ptr_gray),
    .empty        (empty),
    .almost_empty (almost_empty),
    .rd_fill      (rd_fill),
    .rd_valid     (rd_valid),
    .underflow    (underflow)
`ifdef RD_PTR_CTRL_UFLOW_CNT_EN
    ,
    .uflow_cnt    (uflow_cnt)
`endif
  );

  int errors = 0;
  int checks = 0;
  int nvalid = 0;
  int nuf    = 0;

  typedef struct {
    logic [4:0] wr;
    int         n;
    logic [4:0] rdbin;
    logic [4:0] fill;
    logic       e;
    logic       ae;
    int         acc;
  } vec_t;

  vec_t tbl [10];

  function automatic logic [4:0] g(input logic [4:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    if (rd_valid)  nvalid++;
    if (underflow) nuf++;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    read_en = 1'b0;
    wr_ptr_gray = '0;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic chk_reset_vals(input string nm);
    chk({nm, " empty"},  32'(empty), 32'd1);
    chk({nm, " ae"},     32'(almost_empty), 32'd1);
    chk({nm, " fill"},   32'(rd_fill), 32'd0);
    chk({nm, " gray"},   32'(rd_ptr_gray), 32'd0);
    chk({nm, " addr"},   32'(rd_addr), 32'd0);
    chk({nm, " valid"},  32'(rd_valid), 32'd0);
    chk({nm, " uflow"},  32'(underflow), 32'd0);
  endtask

  initial begin
    int rdm, wrv, used, fill_m;
    logic empty_m, ren, acc, uf;
    int hist[$];
    logic [31:0] exp_v, act_v;

    tbl[0] = '{5'd3,  0,  5'd0,  5'd3,  1'b0, 1'b0, 0};
    tbl[1] = '{5'd3,  3,  5'd3,  5'd0,  1'b1, 1'b1, 3};
    tbl[2] = '{5'd10, 2,  5'd5,  5'd5,  1'b0, 1'b0, 2};
    tbl[3] = '{5'd10, 4,  5'd9,  5'd1,  1'b0, 1'b1, 4};
    tbl[4] = '{5'd20, 10, 5'd19, 5'd1,  1'b0, 1'b1, 10};
    tbl[5] = '{5'd30, 0,  5'd19, 5'd11, 1'b0, 1'b0, 0};
    tbl[6] = '{5'd3,  0,  5'd19, 5'd16, 1'b0, 1'b0, 0};
    tbl[7] = '{5'd3,  16, 5'd3,  5'd0,  1'b1, 1'b1, 16};
    tbl[8] = '{5'd5,  4,  5'd5,  5'd0,  1'b1, 1'b1, 2};
    tbl[9] = '{5'd7,  1,  5'd6,  5'd1,  1'b0, 1'b1, 1};

    // Reset state
    rst = 1'b1;
    read_en = 1'b0;
    wr_ptr_gray = '0;
    #1;
    chk_reset_vals("reset");
`ifdef RD_PTR_CTRL_UFLOW_CNT_EN
    chk("reset ucnt", 32'(uflow_cnt), 32'd0);
`endif
    tick();
    rst = 1'b0;
    tick();

    // Write pointer reaches the flags on the third edge
    wr_ptr_gray = g(5'd3);
    tick();
    chk("sync e1 empty", 32'(empty), 32'd1);
    tick();
    chk("sync e2 empty", 32'(empty), 32'd1);
    tick();
    chk("sync e3 empty", 32'(empty), 32'd0);
    chk("sync e3 fill",  32'(rd_fill), 32'd3);
    chk("sync e3 ae",    32'(almost_empty), 32'd0);

    // Four-cycle read burst against three entries
    nvalid = 0;
    nuf = 0;
    read_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (i < 3) chk($sformatf("burst addr%0d", i), 32'(rd_addr), 32'(i));
      tick();
      if (i == 2) chk("burst empty", 32'(empty), 32'd1);
    end
    read_en = 1'b0;
    tick();
    chk("burst valids", 32'(nvalid), 32'd3);
    chk("burst uflows", 32'(nuf), 32'd1);

`ifdef RD_PTR_CTRL_UFLOW_CNT_EN
    chk("ucnt one", 32'(uflow_cnt), 32'd1);
    read_en = 1'b1;
    repeat (300) tick();
    read_en = 1'b0;
    tick();
    chk("ucnt sat", 32'(uflow_cnt), 32'd255);
`endif

    // Vector table
    do_reset();
    foreach (tbl[k]) begin
      wr_ptr_gray = g(tbl[k].wr);
      repeat (4) tick();
      nvalid = 0;
      nuf = 0;
      read_en = 1'b1;
      repeat (tbl[k].n) tick();
      read_en = 1'b0;
      tick();
      tick();
      chk($sformatf("vec%0d addr", k),  32'(rd_addr), 32'(tbl[k].rdbin[3:0]));
      chk($sformatf("vec%0d gray", k),  32'(rd_ptr_gray), 32'(g(tbl[k].rdbin)));
      chk($sformatf("vec%0d fill", k),  32'(rd_fill), 32'(tbl[k].fill));
      chk($sformatf("vec%0d empty", k), 32'(empty), 32'(tbl[k].e));
      chk($sformatf("vec%0d ae", k),    32'(almost_empty), 32'(tbl[k].ae));
      chk($sformatf("vec%0d valid", k), 32'(nvalid), 32'(tbl[k].acc));
      chk($sformatf("vec%0d uflow", k), 32'(nuf), 32'(tbl[k].n - tbl[k].acc));
    end

    // Wrap from 31 to 0
    do_reset();
    wr_ptr_gray = g(5'd31);
    repeat (4) tick();
    read_en = 1'b1;
    repeat (31) tick();
    read_en = 1'b0;
    tick();
    chk("wrap at31 gray", 32'(rd_ptr_gray), 32'h10);
    wr_ptr_gray = g(5'd0);
    repeat (4) tick();
    chk("wrap fill1", 32'(rd_fill), 32'd1);
    chk("wrap addr15", 32'(rd_addr), 32'd15);
    read_en = 1'b1;
    tick();
    read_en = 1'b0;
    chk("wrap gray0", 32'(rd_ptr_gray), 32'd0);
    chk("wrap empty", 32'(empty), 32'd1);
    chk("wrap addr0", 32'(rd_addr), 32'd0);
    chk("wrap fill0", 32'(rd_fill), 32'd0);

    // Reset mid-burst
    do_reset();
    wr_ptr_gray = g(5'd5);
    repeat (4) tick();
    chk("midrst fill5", 32'(rd_fill), 32'd5);
    read_en = 1'b1;
    tick();
    tick();
    #2;
    rst = 1'b1;
    #1;
    chk_reset_vals("midrst");
    nvalid = 0;
    tick();
    tick();
    chk("midrst no valid", 32'(nvalid), 32'd0);
    read_en = 1'b0;
    rst = 1'b0;
    repeat (4) tick();
    chk("midrst refill", 32'(rd_fill), 32'd5);
    chk("midrst addr0", 32'(rd_addr), 32'd0);
    nvalid = 0;
    read_en = 1'b1;
    tick();
    read_en = 1'b0;
    chk("midrst first valid", 32'(nvalid), 32'd1);
    chk("midrst addr1", 32'(rd_addr), 32'd1);

    // Random traffic against the reference model
    do_reset();
    rdm = 0;
    wrv = 0;
    empty_m = 1'b1;
    hist = {0, 0};
    for (int c = 0; c < 400; c++) begin
      ren = 1'($urandom_range(0, 1));
      if (($urandom_range(0, 2) != 0) && (((wrv + 1 - rdm) & 31) <= 16)) wrv = (wrv + 1) & 31;
      read_en = ren;
      wr_ptr_gray = g(5'(wrv));
      hist.push_back(wrv);
      used    = hist[hist.size() - 3];
      acc     = ren && !empty_m;
      uf      = ren && empty_m;
      rdm     = (rdm + int'(acc)) & 31;
      fill_m  = (used - rdm) & 31;
      empty_m = (fill_m == 0);
      exp_v = {14'd0, 4'(rdm), g(5'(rdm)), empty_m, (fill_m <= 2), 5'(fill_m), acc, uf};
      tick();
      act_v = {14'd0, rd_addr, rd_ptr_gray, empty, almost_empty, rd_fill, rd_valid, underflow};
      chk($sformatf("rand c%0d", c), act_v, exp_v);
    end
    read_en = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
